if_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the PC and the IF/ID pipeline register, and handles a req/valid handshake to instruction memory. It takes redirects from the EX-stage branch resolver and from the ID-stage jump decode (the `Jump` encoding produced by the control decoder). The ID stage (decoder, register file) consumes its IF/ID outputs.

---
 rtl/if_stage_pkg.sv | 22 ++
 rtl/if_stage_if.sv | 12 +
 rtl/if_stage_pc_next_sel.sv | 27 ++
 rtl/if_stage.sv | 106 ++++++++++
 tb/tb_if_stage.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared pipeline types and constants for instruction fetch
package if_stage_pkg;

    typedef enum logic [1:0] {
        JUMP_NONE = 2'b00,
        JUMP_IMM  = 2'b01,
        JUMP_REG  = 2'b10
    } jump_t;

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        DROP
    } fetchState_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    function automatic logic [31:0] wordAlign(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory request/response handshake
interface if_stage_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_valid_i;
    logic [31:0] imem_rdata_i;

    modport master (output imem_req_o, imem_addr_o, input imem_valid_i, imem_rdata_i);
    modport slave  (input imem_req_o, imem_addr_o, output imem_valid_i, imem_rdata_i);

endinterface

// File: rtl/if_stage_pc_next_sel.sv
// pc_next_sel: redirect detection and target select for the fetch PC
module pc_next_sel
    import if_stage_pkg::*;
(
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic [1:0]  jumpKind,
    input  logic [25:0] jumpImm,
    input  logic [31:0] jumpReg,
    input  logic [31:0] ifidPc4,
    input  logic        jumpEn,
    output logic        redirect,
    output logic [31:0] target
);

    logic jumpTaken;

    // a resolved branch outranks any jump decoded in ID
    always_comb begin
        jumpTaken = jumpEn && (jumpKind == JUMP_IMM || jumpKind == JUMP_REG);
        redirect  = branchTaken || jumpTaken;
        target    = branchTaken ? wordAlign(branchTarget)
                  : jumpKind == JUMP_IMM ? {ifidPc4[31:28], jumpImm, 2'b00}
                  : wordAlign(jumpReg);
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: PC, fetch handshake FSM and IF/ID pipeline register
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic [1:0]  jump_i,
    input  logic [25:0] jump_imm_i,
    input  logic [31:0] jump_reg_i,
    if_stage_if.master  imem,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc4_o,
    output logic        ifid_valid_o,
    output logic        flush_idex_o
);

    fetchState_t state, nextState;
    logic [31:0] pc, pcNext, pcPlus4, pendPc, holdInstr, target, loadData;
    logic        redirect, done, loadInstr, holdLoad, pendLoad;

    assign pcPlus4 = pc + 32'd4;

    pc_next_sel uSel (
        .branchTaken  (branch_taken_i),
        .branchTarget (branch_target_i),
        .jumpKind     (jump_i),
        .jumpImm      (jump_imm_i),
        .jumpReg      (jump_reg_i),
        .ifidPc4      (ifid_pc4_o),
        .jumpEn       (ifid_valid_o && !stall_i),
        .redirect     (redirect),
        .target       (target)
    );

    // fetch state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= nextState;
    end

    // a redirect without completion must wait out the outstanding fetch in DROP
    always_comb begin
        nextState = state;
        case (state)
            RUN:     nextState = redirect ? (done ? RUN : DROP) : (done && stall_i) ? HOLD : RUN;
            HOLD:    nextState = (redirect || !stall_i) ? RUN : HOLD;
            DROP:    nextState = done ? RUN : DROP;
            default: nextState = RUN;
        endcase
    end

    // memory request follows the state; reset silences request and flush at once
    always_comb begin
        imem.imem_req_o  = !reset && state != HOLD;
        imem.imem_addr_o = wordAlign(pc);
        flush_idex_o     = !reset && branch_taken_i;
    end

    // decide what the next edge loads into PC, pending target, hold buffer and IF/ID
    always_comb begin
        done      = imem.imem_req_o && imem.imem_valid_i;
        loadInstr = !redirect && !stall_i && (state == HOLD || (state == RUN && done));
        holdLoad  = !redirect && stall_i && state == RUN && done;
        pendLoad  = redirect && !done && state != HOLD;
        loadData  = state == HOLD ? holdInstr : imem.imem_rdata_i;
        pcNext    = state == DROP ? (done ? (redirect ? target : pendPc) : pc)
                  : (redirect && (done || state == HOLD)) ? target
                  : loadInstr ? pcPlus4 : pc;
    end

    // PC, pending redirect target and stalled-instruction buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= wordAlign(RESET_PC);
            pendPc    <= '0;
            holdInstr <= NOP_INSTR;
        end else begin
            pc <= pcNext;
            if (pendLoad) pendPc <= target;
            if (holdLoad) holdInstr <= imem.imem_rdata_i;
        end
    end

    // IF/ID register: load, bubble on redirect or empty cycle, freeze on stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_instr_o <= NOP_INSTR;
            ifid_pc4_o   <= '0;
            ifid_valid_o <= 1'b0;
        end else if (loadInstr) begin
            ifid_instr_o <= loadData;
            ifid_pc4_o   <= pcPlus4;
            ifid_valid_o <= 1'b1;
        end else if (redirect || !stall_i) begin
            ifid_instr_o <= NOP_INSTR;
            ifid_pc4_o   <= '0;
            ifid_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: vector table, directed corner sequences and randomized stream checks for if_stage
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] bTarget = '0;
    logic [1:0]  jumpKind = '0;
    logic [25:0] jImm = '0;
    logic [31:0] jReg = '0;
    logic [31:0] ifidInstr, ifidPc4;
    logic        ifidValid, flush;
    logic        memMode = 1'b0;
    logic        tabValid = 1'b0;
    logic        randLat = 1'b0;
    int          memLat = 0;
    int          waitCnt = 0;
    int          checks = 0;
    int          failures = 0;

    if_stage_if imem();

    if_stage #(.RESET_PC(32'h0)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall),
        .branch_taken_i  (branch),
        .branch_target_i (bTarget),
        .jump_i          (jumpKind),
        .jump_imm_i      (jImm),
        .jump_reg_i      (jReg),
        .imem            (imem),
        .ifid_instr_o    (ifidInstr),
        .ifid_pc4_o      (ifidPc4),
        .ifid_valid_o    (ifidValid),
        .flush_idex_o    (flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return 32'h8000_0000 | (a >> 2);
    endfunction

    // memory: data is a fixed function of the address; valid from the table or a wait counter
    always_comb begin
        imem.imem_valid_i = memMode ? (imem.imem_req_o && waitCnt == 0) : tabValid;
        imem.imem_rdata_i = memData(imem.imem_addr_o);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) waitCnt <= memLat;
        else if (imem.imem_req_o && imem.imem_valid_i) waitCnt <= randLat ? int'($urandom_range(0, 2)) : memLat;
        else if (imem.imem_req_o && waitCnt > 0) waitCnt <= waitCnt - 1;
    end

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        s;
        logic        b;
        logic [31:0] bt;
        logic [1:0]  jk;
        logic [25:0] ji;
        logic [31:0] jr;
        logic        mv;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eFlush;
        logic        eV;
        logic [31:0] ePc4;
    } vec_t;

    vec_t tab[$];

    task automatic add(input logic s, input logic b, input logic [31:0] bt, input logic [1:0] jk,
                       input logic [25:0] ji, input logic [31:0] jr, input logic mv,
                       input logic eReq, input logic [31:0] eAddr, input logic eFlush,
                       input logic eV, input logic [31:0] ePc4);
        vec_t v;
        v.s = s; v.b = b; v.bt = bt; v.jk = jk; v.ji = ji; v.jr = jr; v.mv = mv;
        v.eReq = eReq; v.eAddr = eAddr; v.eFlush = eFlush; v.eV = eV; v.ePc4 = ePc4;
        tab.push_back(v);
    endtask

    // stream reference: the ID stage must see the instructions of the architectural PC sequence
    logic [31:0] expPc, prevAddr;
    logic [64:0] prevIfid;
    logic        prevPend, prevFreeze, sawHold;
    int          consumed;

    task automatic modelReset();
        expPc = 32'h0;
        prevPend = 1'b0;
        prevFreeze = 1'b0;
        consumed = 0;
    endtask

    task automatic modelCycle(input logic s, input logic b, input logic [31:0] bt, input logic [1:0] jk,
                              input logic [25:0] ji, input logic [31:0] jr);
        logic [31:0] pc4;
        stall = s; branch = b; bTarget = bt; jImm = ji; jReg = jr;
        jumpKind = (ifidValid && !s) ? jk : 2'b00;
        #1;
        if (prevPend) chk("addr_stable", 65'({imem.imem_req_o, imem.imem_addr_o}), 65'({1'b1, prevAddr}));
        if (prevFreeze) chk("ifid_frozen", 65'({ifidValid, ifidPc4, ifidInstr}), prevIfid);
        chk("flush", 65'(flush), 65'(b));
        if (!imem.imem_req_o) sawHold = 1'b1;
        if (ifidValid && !s && !b) begin
            pc4 = expPc + 32'd4;
            chk("stream_pc4", 65'(ifidPc4), 65'(pc4));
            chk("stream_instr", 65'(ifidInstr), 65'(memData(expPc)));
            consumed++;
            expPc = jumpKind == 2'b01 ? {pc4[31:28], ji, 2'b00}
                  : jumpKind == 2'b10 ? {jr[31:2], 2'b00} : pc4;
        end
        if (b) expPc = {bt[31:2], 2'b00};
        prevPend = imem.imem_req_o && !imem.imem_valid_i;
        prevAddr = imem.imem_addr_o;
        prevFreeze = s && !b;
        prevIfid = {ifidValid, ifidPc4, ifidInstr};
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) modelCycle(1'b0, 1'b0, 32'h0, 2'b00, 26'h0, 32'h0);
    endtask

    task automatic restart(input int lat);
        memLat = lat;
        stall = 1'b0; branch = 1'b0; jumpKind = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic checkResetValues(input string tag);
        chk({tag, "_req"}, 65'(imem.imem_req_o), 65'(1'b0));
        chk({tag, "_addr"}, 65'(imem.imem_addr_o), 65'(32'h0));
        chk({tag, "_valid"}, 65'(ifidValid), 65'(1'b0));
        chk({tag, "_instr"}, 65'(ifidInstr), 65'(32'h0));
        chk({tag, "_pc4"}, 65'(ifidPc4), 65'(32'h0));
        chk({tag, "_flush"}, 65'(flush), 65'(1'b0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //  s  b  bt            jk     ji      jr            mv | req addr          flush v  pc4
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        1,  1, 32'h0,         0,    0, 32'h0);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        1,  1, 32'h4,         0,    1, 32'h4);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        1,  1, 32'h8,         0,    1, 32'h8);
        add(0, 0, 32'h0,        2'd1, 26'h40, 32'h0,        1,  1, 32'hC,         0,    1, 32'hC);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        1,  1, 32'h100,       0,    0, 32'h0);
        add(0, 1, 32'h200,      2'd2, 26'h0,  32'h300,      1,  1, 32'h104,       1,    1, 32'h104);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        0,  1, 32'h200,       0,    0, 32'h0);
        add(1, 0, 32'h0,        2'd0, 26'h0,  32'h0,        1,  1, 32'h200,       0,    0, 32'h0);
        add(1, 0, 32'h0,        2'd0, 26'h0,  32'h0,        1,  0, 32'h200,       0,    0, 32'h0);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        0,  0, 32'h200,       0,    0, 32'h0);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        1,  1, 32'h204,       0,    1, 32'h204);
        add(0, 0, 32'h0,        2'd2, 26'h0,  32'h403,      0,  1, 32'h208,       0,    1, 32'h208);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        0,  1, 32'h208,       0,    0, 32'h0);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        1,  1, 32'h208,       0,    0, 32'h0);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        1,  1, 32'h400,       0,    0, 32'h0);
        add(1, 0, 32'h0,        2'd0, 26'h0,  32'h0,        1,  1, 32'h404,       0,    1, 32'h404);
        add(1, 0, 32'h0,        2'd1, 26'h3,  32'h0,        1,  0, 32'h404,       0,    1, 32'h404);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        0,  0, 32'h404,       0,    1, 32'h404);
        add(0, 1, 32'hFFFF_FFFC,2'd0, 26'h0,  32'h0,        1,  1, 32'h408,       1,    1, 32'h408);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        1,  1, 32'hFFFF_FFFC, 0,    0, 32'h0);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        1,  1, 32'h0,         0,    1, 32'h0);
        add(0, 1, 32'h1000_0004,2'd0, 26'h0,  32'h0,        1,  1, 32'h4,         1,    1, 32'h4);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        1,  1, 32'h1000_0004, 0,    0, 32'h0);
        add(0, 0, 32'h0,        2'd1, 26'h40, 32'h0,        1,  1, 32'h1000_0008, 0,    1, 32'h1000_0008);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        1,  1, 32'h1000_0100, 0,    0, 32'h0);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        1,  1, 32'h1000_0104, 0,    1, 32'h1000_0104);
        add(0, 1, 32'h40,       2'd0, 26'h0,  32'h0,        1,  1, 32'h1000_0108, 1,    1, 32'h1000_0108);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        0,  1, 32'h40,        0,    0, 32'h0);
        add(0, 1, 32'h200,      2'd0, 26'h0,  32'h0,        0,  1, 32'h40,        1,    0, 32'h0);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        0,  1, 32'h40,        0,    0, 32'h0);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        1,  1, 32'h40,        0,    0, 32'h0);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        1,  1, 32'h200,       0,    0, 32'h0);
        add(0, 0, 32'h0,        2'd0, 26'h0,  32'h0,        1,  1, 32'h204,       0,    1, 32'h204);

        @(negedge clk);
        #1;
        checkResetValues("reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < tab.size(); i++) begin
            stall = tab[i].s; branch = tab[i].b; bTarget = tab[i].bt;
            jumpKind = tab[i].jk; jImm = tab[i].ji; jReg = tab[i].jr; tabValid = tab[i].mv;
            #1;
            chk($sformatf("tab%0d_req", i), 65'(imem.imem_req_o), 65'(tab[i].eReq));
            chk($sformatf("tab%0d_addr", i), 65'(imem.imem_addr_o), 65'(tab[i].eAddr));
            chk($sformatf("tab%0d_flush", i), 65'(flush), 65'(tab[i].eFlush));
            chk($sformatf("tab%0d_valid", i), 65'(ifidValid), 65'(tab[i].eV));
            chk($sformatf("tab%0d_pc4", i), 65'(ifidPc4), 65'(tab[i].ePc4));
            chk($sformatf("tab%0d_instr", i), 65'(ifidInstr),
                65'(tab[i].eV ? memData(tab[i].ePc4 - 32'd4) : 32'h0));
            @(negedge clk);
        end

        memMode = 1'b1;
        restart(1);
        sawHold = 1'b0;
        idle(5);
        for (int k = 0; k < 3; k++) modelCycle(1'b1, 1'b0, 32'h0, 2'b00, 26'h0, 32'h0);
        idle(8);
        chk("stall_hold_entered", 65'(sawHold), 65'(1'b1));
        chk("stall_progress", 65'(consumed >= 4), 65'(1'b1));

        restart(2);
        idle(3);
        modelCycle(1'b0, 1'b1, 32'h200, 2'b00, 26'h0, 32'h0);
        idle(1);
        #2 reset = 1'b1;
        #1;
        checkResetValues("rst_drop");
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        idle(8);
        chk("rst_drop_progress", 65'(consumed >= 1), 65'(1'b1));

        restart(0);
        sawHold = 1'b0;
        idle(1);
        modelCycle(1'b1, 1'b0, 32'h0, 2'b00, 26'h0, 32'h0);
        modelCycle(1'b1, 1'b0, 32'h0, 2'b00, 26'h0, 32'h0);
        chk("rst_hold_entered", 65'(sawHold), 65'(1'b1));
        stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        checkResetValues("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        idle(6);
        chk("rst_hold_progress", 65'(consumed >= 4), 65'(1'b1));

        randLat = 1'b1;
        restart(1);
        for (int k = 0; k < 1500; k++) begin
            modelCycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom & 32'h0000_FFFF,
                       $urandom_range(0, 5) == 0 ? 2'($urandom_range(1, 2)) : 2'b00,
                       26'($urandom), $urandom);
        end
        chk("random_progress", 65'(consumed > 100), 65'(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
